// File: rtl/gpio_pkg.sv
// ============================================================================
// Module      : gpio_pkg
// Description : Register word indexes and channel limit for gpio_edge_capture.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gpio_pkg;

   localparam int GPIO_MAX_CH = 32;

   localparam logic [2:0] GPIO_DATA  = 3'd0;
   localparam logic [2:0] GPIO_EDGE  = 3'd1;
   localparam logic [2:0] GPIO_RISE  = 3'd2;
   localparam logic [2:0] GPIO_FALL  = 3'd3;
   localparam logic [2:0] GPIO_IRQEN = 3'd4;

endpackage

`default_nettype wire

// File: rtl/gpio_edge_capture_sync_debounce.sv
// ============================================================================
// Module      : sync_debounce
// Description : One-channel synchroniser plus stable-count debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_debounce #(
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = 250000,
   parameter logic RESET_LEVEL     = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic pin_i,
   output logic db,
   output logic rise_p,
   output logic fall_p
);

   localparam int c_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [c_cnt_w-1:0]     r_cnt;
   logic                   r_db;
   logic                   w_s;
   logic                   w_mismatch;
   logic                   w_fire;

   assign w_s        = r_sync[SYNC_STAGES-1];
   assign w_mismatch = w_s ^ r_db;
   assign w_fire     = w_mismatch && (r_cnt == c_cnt_max);

   // Pulses are asserted in the cycle before db flips so the edge flag
   // register captures on the very clock edge that db changes.
   assign rise_p = w_fire & w_s;
   assign fall_p = w_fire & ~w_s;
   assign db     = r_db;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync <= {SYNC_STAGES{RESET_LEVEL}};
         r_cnt  <= '0;
         r_db   <= RESET_LEVEL;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], pin_i};
         if (!w_mismatch) begin
            r_cnt <= '0;
         end else if (w_fire) begin
            r_db  <= w_s;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/gpio_edge_capture.sv
// ============================================================================
// Module      : gpio_edge_capture
// Description : Debounced GPIO inputs with sticky W1C edge flags and IRQ.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_edge_capture
   import gpio_pkg::*;
#(
   parameter int              N_CH            = 10,
   parameter int              DEBOUNCE_CYCLES = 250000,
   parameter int              SYNC_STAGES     = 2,
   parameter logic [N_CH-1:0] RESET_LEVEL     = '0
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [N_CH-1:0] pins_i,
   input  logic            we,
   input  logic [4:0]      addr,
   input  logic [31:0]     wdata,
   output logic [31:0]     rdata,
   output logic [N_CH-1:0] level_o,
   output logic            irq
);

   logic [N_CH-1:0] w_db;
   logic [N_CH-1:0] w_rise;
   logic [N_CH-1:0] w_fall;
   logic [N_CH-1:0] w_wdata_ch;
   logic [N_CH-1:0] w_set;
   logic [N_CH-1:0] w_clr;
   logic [N_CH-1:0] w_rd;
   logic [2:0]      w_word;
   logic            w_unused;

   logic [N_CH-1:0] r_edge;
   logic [N_CH-1:0] r_rise_en;
   logic [N_CH-1:0] r_fall_en;
   logic [N_CH-1:0] r_irq_en;
   logic            r_irq;

   generate
      for (genvar i = 0; i < N_CH; i++) begin : g_ch
         sync_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (RESET_LEVEL[i])
         ) u_sync_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .pin_i   (pins_i[i]),
            .db      (w_db[i]),
            .rise_p  (w_rise[i]),
            .fall_p  (w_fall[i])
         );
      end
   endgenerate

   assign w_word     = addr[4:2];
   assign w_wdata_ch = wdata[N_CH-1:0];
   assign w_unused   = ^{addr[1:0], wdata};

   // A new edge in the same cycle as a clear keeps the flag set.
   assign w_set = (w_rise & r_rise_en) | (w_fall & r_fall_en);
   assign w_clr = (we && (w_word == GPIO_EDGE)) ? w_wdata_ch : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_edge    <= '0;
         r_rise_en <= '0;
         r_fall_en <= '0;
         r_irq_en  <= '0;
         r_irq     <= 1'b0;
      end else begin
         r_edge <= (r_edge & ~w_clr) | w_set;
         if (we && (w_word == GPIO_RISE))  r_rise_en <= w_wdata_ch;
         if (we && (w_word == GPIO_FALL))  r_fall_en <= w_wdata_ch;
         if (we && (w_word == GPIO_IRQEN)) r_irq_en  <= w_wdata_ch;
         r_irq <= |(r_edge & r_irq_en);
      end
   end

   always_comb begin
      w_rd = '0;
      case (w_word)
         GPIO_DATA:  w_rd = w_db;
         GPIO_EDGE:  w_rd = r_edge;
         GPIO_RISE:  w_rd = r_rise_en;
         GPIO_FALL:  w_rd = r_fall_en;
         GPIO_IRQEN: w_rd = r_irq_en;
         default:    w_rd = '0;
      endcase
      rdata            = '0;
      rdata[N_CH-1:0]  = w_rd;
   end

   assign level_o = w_db;
   assign irq     = r_irq;

endmodule

`default_nettype wire

// File: doc/gpio_edge_capture.md
# gpio_edge_capture

Memory-mapped, parametrised input peripheral for the RISC-V multicycle system. It samples N_CH asynchronous board inputs (SW, KEY), synchronises and debounces each one, and latches configurable rising/falling edges into sticky write-1-to-clear flags. It raises a level interrupt from those flags. It sits on the CPU data bus beside the LED/HEX output registers, so software no longer polls raw switch levels and tracks edges itself.

## Interface
- N_CH, 10: number of input channels, 1..32.
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles required before the debounced level changes (5 ms at 50 MHz); ≥1.
- SYNC_STAGES, 2: synchroniser flip-flop depth; ≥2.
- RESET_LEVEL, '0 (N_CH bits): reset value of the synchroniser and debounced level per channel. Set to 1 for active-low KEY channels.
- clk  in  1  system clock (CLOCK_50 at top).
- reset_n  in  1  asynchronous, active-low reset.
- pins_i  in  N_CH  raw asynchronous inputs.
- we  in  1  bus write strobe, one cycle.
- addr  in  5  byte address within block; bits [1:0] ignored.
- wdata  in  32  write data.
- rdata  out  32  read data, combinational from addr.
- level_o  out  N_CH  debounced levels (direct LED drive).
- irq  out  1  registered interrupt request.

## Operation
- Register map (word index addr[4:2]):
  - 0 DATA: RO, debounced levels.
  - 1 EDGE: W1C, sticky edge flags.
  - 2 RISE_EN: RW.
  - 3 FALL_EN: RW.
  - 4 IRQ_EN: RW.
  - 5–7: read 0; writes ignored.
- Bits above N_CH read 0. Writes to DATA are ignored. Reads have no side effects.
- Per channel, s is the synchroniser output, db the debounced level, cnt a counter of $clog2(DEBOUNCE_CYCLES) bits (min 1):
  - s==db → cnt←0.
  - s≠db and cnt==DEBOUNCE_CYCLES−1 → db←s, cnt←0.
  - else → cnt←cnt+1.
- A db update 0→1 with RISE_EN[i]=1, or 1→0 with FALL_EN[i]=1, sets EDGE[i] on the same edge that db changes.
- W1C: a write to EDGE clears bits where wdata=1. If a set and a clear hit the same bit in the same cycle, the set wins and the bit stays 1.
- Enable changes do not retroactively capture or clear flags.
- irq ← |(EDGE & IRQ_EN) each cycle.
- Reset values:
  - synchronisers and db: RESET_LEVEL.
  - cnt, EDGE, RISE_EN, FALL_EN, IRQ_EN, irq: 0.
  - level_o: RESET_LEVEL.
  - rdata: follows the map.

## Timing
- Edge E is the first clock edge that samples a new stable pin level. db, level_o, DATA and EDGE update at edge E+SYNC_STAGES+DEBOUNCE_CYCLES−1.
- irq updates one cycle after that.
- A mismatch shorter than DEBOUNCE_CYCLES consecutive cycles at s resets cnt and produces no change (glitch rejection).
- A register write takes effect at the clk edge where we=1. A read of the same register in the following cycle returns the new value.
- irq falls one cycle after the W1C write or the IRQ_EN write that removes the last enabled flag.
- Asserting reset_n low forces all state to reset values immediately, including mid-count. After release, a full SYNC_STAGES+DEBOUNCE_CYCLES interval is required before any change.
- Channels are fully independent. Simultaneous edges on several channels all capture in the same cycle.

## Structure
- Package gpio_pkg holds:
  - register word-index constants (GPIO_DATA=0, GPIO_EDGE=1, GPIO_RISE=2, GPIO_FALL=3, GPIO_IRQEN=4);
  - the N_CH ≤ 32 limit constant.
- Sub-module sync_debounce: one channel, with parameters SYNC_STAGES, DEBOUNCE_CYCLES, RESET_LEVEL (1 bit).
  - Outputs: db, rise_p, fall_p (single-cycle pulses on db change).
  - Instantiated N_CH times via generate.
- The top module contains the register file, W1C logic, irq flop and read mux.

## Test plan
Bench parameters: N_CH=10, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_LEVEL=10'h000 unless stated.
- Reset: reset_n=0 with pins_i=10'h3FF and RESET_LEVEL=10'h3FF → after release, DATA=0x3FF, EDGE=0, irq=0, and no capture ever occurs while pins stay constant.
- Rising edge: write RISE_EN=0x2 and IRQ_EN=0x2, then pins_i[1] 0→1 first sampled at edge E → DATA=0x2 and EDGE=0x2 at E+5, irq=1 at E+6.
- Bounce: pins_i[1] toggles with high/low pulses of 3 cycles for 40 cycles, then returns low → DATA, EDGE and irq unchanged throughout.
- W1C and collision:
  - Write EDGE=0x2 → EDGE=0 and irq=0 the next cycle.
  - Repeat with a new enabled edge on bit 1 landing in the write cycle → EDGE[1] stays 1 and irq stays 1.
- Fall-only: FALL_EN=0x1, RISE_EN=0, IRQ_EN=0.
  - Bit 0 rises → EDGE=0.
  - Bit 0 falls → EDGE=0x1, irq stays 0.
  - Then write IRQ_EN=0x1 → irq=1 the next cycle.
- Reset mid-debounce: pins_i[3] rises, and reset_n pulses low when cnt=2 → DATA[3]=0 and EDGE=0 immediately. With the pin held high, DATA[3]=1 exactly 5 edges after the first post-reset sampling edge.
